// File: rtl/ascon_pack.sv
// Shared Ascon-128 constants, state type and round helpers.
package ascon_pack;

    typedef logic [63:0] u64_t;

    typedef struct packed {
        u64_t x0;
        u64_t x1;
        u64_t x2;
        u64_t x3;
        u64_t x4;
    } ascon_state_t;

    localparam int   STATE_W       = 320;
    localparam int   ROUND_WIDTH   = 4;
    localparam int   PA_ROUNDS     = 12;
    localparam int   PB_ROUNDS     = 6;
    localparam u64_t ASCON128_IV   = 64'h8040_0c06_0000_0000;
    localparam u64_t PAD_CONST     = 64'h8000_0000_0000_0000;
    localparam u64_t DOM_SEP_CONST = 64'h0000_0000_0000_0001;

    function automatic logic [7:0] RndConst(input logic [ROUND_WIDTH-1:0] r);
        return {4'hf - r, r};
    endfunction

    // Bitsliced 5-bit S-box; v = {x0,x1,x2,x3,x4} of one column.
    function automatic logic [4:0] Sbox(input logic [4:0] v);
        logic a0, a1, a2, a3, a4;
        logic b0, b1, b2, b3, b4;
        a0 = v[4] ^ v[0];
        a1 = v[3];
        a2 = v[2] ^ v[3];
        a3 = v[1];
        a4 = v[0] ^ v[1];
        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);
        return {b0 ^ b4, b1 ^ b0, ~b2, b3 ^ b2, b4};
    endfunction

    function automatic u64_t Ror(input u64_t v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round: constant add, S-box layer, linear layer.
module ascon_round
    import ascon_pack::*;
(
    input  logic [STATE_W-1:0]     i_state,
    input  logic [ROUND_WIDTH-1:0] i_rnd,
    output logic [STATE_W-1:0]     o_state
);

    ascon_state_t w_in;
    u64_t         w_c2;
    u64_t         w_s0, w_s1, w_s2, w_s3, w_s4;

    assign w_in = i_state;
    assign w_c2 = w_in.x2 ^ {56'd0, RndConst(i_rnd)};

    for (genvar b = 0; b < 64; b++) begin : g_sbox
        assign {w_s0[b], w_s1[b], w_s2[b], w_s3[b], w_s4[b]} =
            Sbox({w_in.x0[b], w_in.x1[b], w_c2[b], w_in.x3[b], w_in.x4[b]});
    end

    assign o_state = {w_s0 ^ Ror(w_s0, 19) ^ Ror(w_s0, 28),
                      w_s1 ^ Ror(w_s1, 61) ^ Ror(w_s1, 39),
                      w_s2 ^ Ror(w_s2,  1) ^ Ror(w_s2,  6),
                      w_s3 ^ Ror(w_s3, 10) ^ Ror(w_s3, 17),
                      w_s4 ^ Ror(w_s4,  7) ^ Ror(w_s4, 41)};

endmodule

// File: rtl/ascon_dec_core.sv
// Iterative Ascon-128 decryption, one round per clock, whole 8-byte blocks only.
// Define IMT_ASCON_DEC_TAG_OUT_EN to expose the computed tag on tag_o during CMP.
module ascon_dec_core
    import ascon_pack::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         has_ad_i,
    input  logic         has_ct_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [127:0] tag_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [63:0]  in_data_i,
    input  logic         in_last_i,
    output logic         pt_valid_o,
    output logic [63:0]  pt_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         tag_ok_o
`ifdef IMT_ASCON_DEC_TAG_OUT_EN
    ,
    output logic [127:0] tag_o
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_AD_WAIT, S_AD_PERM, S_AD_PAD,
        S_CT_WAIT, S_CT_PERM, S_FINAL, S_CMP
    } state_t;

    localparam logic [ROUND_WIDTH-1:0] RND_PA   = '0;
    localparam logic [ROUND_WIDTH-1:0] RND_PB   = ROUND_WIDTH'(PA_ROUNDS - PB_ROUNDS);
    localparam logic [ROUND_WIDTH-1:0] RND_LAST = ROUND_WIDTH'(PA_ROUNDS - 1);

    state_t                 r_state, w_nstate;
    logic [ROUND_WIDTH-1:0] r_rnd, w_rnd, w_rnd_nxt;
    ascon_state_t           r_x, w_rin, w_rout, w_post;
    logic [127:0]           r_key, r_tag;
    logic [63:0]            r_pt;
    logic                   r_has_ad, r_has_ct, r_last, r_pt_vld, r_tag_ok;
    logic                   w_hs, w_run, w_last_rnd, w_match;

    assign in_ready_o = (r_state == S_AD_WAIT) || (r_state == S_CT_WAIT);
    assign w_hs       = in_ready_o && in_valid_i;
    // A WAIT handshake executes the first pb round in the same cycle.
    assign w_rnd      = in_ready_o ? RND_PB : r_rnd;
    assign w_last_rnd = (w_rnd == RND_LAST);
    assign w_match    = ~|({r_x.x3, r_x.x4} ^ r_tag);

    ascon_round u_round (
        .i_state (w_rin),
        .i_rnd   (w_rnd),
        .o_state (w_rout)
    );

    always_comb begin : p_next
        w_nstate  = r_state;
        w_run     = 1'b0;
        w_rin     = r_x;
        w_rnd_nxt = r_rnd;
        case (r_state)
            S_IDLE: if (start_i) w_nstate = S_INIT;
            S_INIT: begin
                w_run = 1'b1;
                if (w_last_rnd)
                    w_nstate = r_has_ad ? S_AD_WAIT : (r_has_ct ? S_CT_WAIT : S_FINAL);
            end
            S_AD_WAIT: if (w_hs) begin
                w_run    = 1'b1;
                w_rin.x0 = r_x.x0 ^ in_data_i;
                w_nstate = S_AD_PERM;
            end
            S_AD_PERM: begin
                w_run = 1'b1;
                if (w_last_rnd) w_nstate = r_last ? S_AD_PAD : S_AD_WAIT;
            end
            S_AD_PAD: begin
                w_run = 1'b1;
                if (w_rnd == RND_PB) w_rin.x0 = r_x.x0 ^ PAD_CONST;
                if (w_last_rnd) w_nstate = r_has_ct ? S_CT_WAIT : S_FINAL;
            end
            S_CT_WAIT: if (w_hs) begin
                w_run    = 1'b1;
                w_rin.x0 = in_data_i;
                w_nstate = S_CT_PERM;
            end
            S_CT_PERM: begin
                w_run = 1'b1;
                if (w_last_rnd) w_nstate = r_last ? S_FINAL : S_CT_WAIT;
            end
            S_FINAL: begin
                w_run = 1'b1;
                if (w_rnd == RND_PA) begin
                    w_rin.x0 = r_x.x0 ^ PAD_CONST;
                    w_rin.x1 = r_x.x1 ^ r_key[127:64];
                    w_rin.x2 = r_x.x2 ^ r_key[63:0];
                end
                if (w_last_rnd) w_nstate = S_CMP;
            end
            S_CMP:   w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase

        if (r_state == S_IDLE)
            w_rnd_nxt = RND_PA;
        else if (w_run) begin
            if (!w_last_rnd)               w_rnd_nxt = w_rnd + ROUND_WIDTH'(1);
            else if (w_nstate == S_FINAL)  w_rnd_nxt = RND_PA;
            else                           w_rnd_nxt = RND_PB;
        end
    end

    always_comb begin : p_post
        w_post = w_rout;
        if (w_last_rnd) begin
            case (r_state)
                S_INIT: begin
                    w_post.x3 = w_rout.x3 ^ r_key[127:64];
                    w_post.x4 = w_rout.x4 ^ r_key[63:0] ^ (r_has_ad ? 64'd0 : DOM_SEP_CONST);
                end
                S_AD_PAD: w_post.x4 = w_rout.x4 ^ DOM_SEP_CONST;
                S_FINAL: begin
                    w_post.x3 = w_rout.x3 ^ r_key[127:64];
                    w_post.x4 = w_rout.x4 ^ r_key[63:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nstate;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rnd    <= '0;
            r_x      <= '0;
            r_key    <= '0;
            r_tag    <= '0;
            r_has_ad <= 1'b0;
            r_has_ct <= 1'b0;
            r_last   <= 1'b0;
            r_pt     <= '0;
            r_pt_vld <= 1'b0;
            r_tag_ok <= 1'b0;
        end else begin
            r_rnd    <= w_rnd_nxt;
            r_pt_vld <= 1'b0;
            if (w_run) r_x <= w_post;
            if (r_state == S_IDLE && start_i) begin
                r_x      <= {ASCON128_IV, key_i, nonce_i};
                r_key    <= key_i;
                r_tag    <= tag_i;
                r_has_ad <= has_ad_i;
                r_has_ct <= has_ct_i;
                r_tag_ok <= 1'b0;
            end
            if (w_hs) r_last <= in_last_i;
            if (r_state == S_CT_WAIT && w_hs) begin
                r_pt     <= r_x.x0 ^ in_data_i;
                r_pt_vld <= 1'b1;
            end
            if (r_state == S_CMP) r_tag_ok <= w_match;
        end
    end

    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_CMP);
    assign tag_ok_o   = done_o ? w_match : r_tag_ok;
    assign pt_o       = r_pt;
    assign pt_valid_o = r_pt_vld;

`ifdef IMT_ASCON_DEC_TAG_OUT_EN
    assign tag_o = done_o ? {r_x.x3, r_x.x4} : 128'd0;
`endif

endmodule

// File: tb/tb_ascon_dec_core.sv
// Directed bench for ascon_dec_core: empty-message KAT, bad tag, AD+CT and CT-only
// messages against a table-driven Ascon model, and reset in the middle of a message.
module tb_ascon_dec_core;

    localparam logic [127:0] KN      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;
    localparam logic [159:0] SBOX_T  = {5'h04,5'h0b,5'h1f,5'h14,5'h1a,5'h15,5'h09,5'h02,
                                        5'h1b,5'h05,5'h08,5'h12,5'h1d,5'h03,5'h06,5'h1c,
                                        5'h1e,5'h13,5'h07,5'h0e,5'h00,5'h0d,5'h11,5'h18,
                                        5'h10,5'h0c,5'h01,5'h19,5'h16,5'h0a,5'h0f,5'h17};

    logic         clk = 1'b0;
    logic         rst_n, start_i, has_ad_i, has_ct_i;
    logic [127:0] key_i, nonce_i, tag_i;
    logic         in_valid_i, in_ready_o, in_last_i;
    logic [63:0]  in_data_i, pt_o;
    logic         pt_valid_o, busy_o, done_o, tag_ok_o;
`ifdef IMT_ASCON_DEC_TAG_OUT_EN
    logic [127:0] tag_o;
`endif

    always #5 clk = ~clk;

    ascon_dec_core dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .has_ad_i(has_ad_i), .has_ct_i(has_ct_i),
        .key_i(key_i), .nonce_i(nonce_i), .tag_i(tag_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_last_i(in_last_i), .pt_valid_o(pt_valid_o), .pt_o(pt_o),
        .busy_o(busy_o), .done_o(done_o), .tag_ok_o(tag_ok_o)
`ifdef IMT_ASCON_DEC_TAG_OUT_EN
        , .tag_o(tag_o)
`endif
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] blk [8];
    logic [63:0] exp_pt [8];

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] mround(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col, o;
        for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
        x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
        for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o   = SBOX_T[159-5*int'(col) -: 5];
            for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
        end
        return {y[0] ^ ror(y[0], 19) ^ ror(y[0], 28), y[1] ^ ror(y[1], 61) ^ ror(y[1], 39),
                y[2] ^ ror(y[2],  1) ^ ror(y[2],  6), y[3] ^ ror(y[3], 10) ^ ror(y[3], 17),
                y[4] ^ ror(y[4],  7) ^ ror(y[4], 41)};
    endfunction

    function automatic logic [319:0] mperm(input logic [319:0] s, input int first);
        logic [319:0] t;
        t = s;
        for (int r = first; r < 12; r++) t = mround(t, r);
        return t;
    endfunction

    task automatic model(input logic [127:0] k, input logic [127:0] n, input int nad,
                         input int nct, output logic [127:0] tag);
        logic [319:0] s;
        s = mperm({64'h80400c0600000000, k, n}, 0);
        s[127:0] = s[127:0] ^ k;
        for (int i = 0; i < nad; i++) begin
            s[319:256] = s[319:256] ^ blk[i];
            s = mperm(s, 6);
        end
        if (nad > 0) begin
            s[319:256] = s[319:256] ^ 64'h8000000000000000;
            s = mperm(s, 6);
        end
        s[0] = ~s[0];
        for (int i = 0; i < nct; i++) begin
            exp_pt[i]  = s[319:256] ^ blk[nad+i];
            s[319:256] = blk[nad+i];
            s = mperm(s, 6);
        end
        s[319:256] = s[319:256] ^ 64'h8000000000000000;
        s[255:128] = s[255:128] ^ k;
        s = mperm(s, 0);
        tag = s[127:0] ^ k;
    endtask

    // ---------------- message driver / observer ----------------
    logic [63:0]  got_pt [8];
    int           pt_cyc [8];
    int           hs_cyc [8];
    int           npt, nhs, nrdy, done_cyc;
    bit           busy_bad, busy_after, ok_at_done, ok_after, tag_o_bad;
    logic [127:0] exp_ctag;

    // Called half a cycle away from the edge; the cycle driving start_i is cycle 0.
    task automatic run_msg(input logic [127:0] k, input logic [127:0] n, input logic [127:0] t,
                           input int nad, input int nct, input bit always_v,
                           input int stop_at, input int start_glitch);
        int idx, cyc;
        bit vld, rdy;
        key_i = k; nonce_i = n; tag_i = t;
        has_ad_i = (nad > 0); has_ct_i = (nct > 0);
        start_i = 1'b1; in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = '0;
        npt = 0; nhs = 0; nrdy = 0; done_cyc = -1; idx = 0;
        busy_bad = 0; busy_after = 1; ok_at_done = 0; ok_after = 0; tag_o_bad = 0;
        @(posedge clk); #1;
        start_i = 1'b0; cyc = 1;
        key_i = ~k; nonce_i = ~n; tag_i = ~t; has_ad_i = ~has_ad_i; has_ct_i = ~has_ct_i;
        while (cyc < 200) begin
            if (done_cyc >= 0) begin
                busy_after = busy_o;
                ok_after   = tag_ok_o;
                break;
            end
            if (cyc == stop_at) begin
                in_valid_i = 1'b0;
                return;
            end
            if (!busy_o) busy_bad = 1;
            if (pt_valid_o && npt < 8) begin
                got_pt[npt] = pt_o; pt_cyc[npt] = cyc; npt++;
            end
            if (in_ready_o) nrdy++;
`ifdef IMT_ASCON_DEC_TAG_OUT_EN
            if (tag_o !== (done_o ? exp_ctag : 128'd0)) tag_o_bad = 1;
`endif
            if (done_o) begin
                done_cyc   = cyc;
                ok_at_done = tag_ok_o;
            end
            rdy        = in_ready_o;
            vld        = (idx < nad + nct) && (always_v || rdy);
            in_valid_i = vld;
            in_data_i  = vld ? blk[idx] : 64'd0;
            in_last_i  = vld && (idx == nad - 1 || idx == nad + nct - 1);
            start_i    = (cyc == start_glitch);
            @(posedge clk);
            if (vld && rdy) begin
                if (nhs < 8) hs_cyc[nhs] = cyc;
                nhs++; idx++;
            end
            #1;
            cyc++;
        end
        in_valid_i = 1'b0; start_i = 1'b0;
    endtask

    task automatic s_empty(input logic [127:0] t, input logic exp_ok, input string nm);
        exp_ctag = KAT_TAG;
        run_msg(KN, KN, t, 0, 0, 1'b0, -1, -1);
        chk({nm, "_done_cyc"}, 128'(done_cyc), 128'(25));
        chk({nm, "_tag_ok"},   128'(ok_at_done), 128'(exp_ok));
        chk({nm, "_tag_held"}, 128'(ok_after), 128'(exp_ok));
        chk({nm, "_busy"},     128'(busy_bad), 128'(0));
        chk({nm, "_idle"},     128'(busy_after), 128'(0));
        chk({nm, "_npt"},      128'(npt), 128'(0));
        chk({nm, "_nrdy"},     128'(nrdy), 128'(0));
`ifdef IMT_ASCON_DEC_TAG_OUT_EN
        chk({nm, "_tag_o"},    128'(tag_o_bad), 128'(0));
`endif
    endtask

    initial begin
        logic [127:0] mt;
        bit           rst_done;
        rst_n = 1'b0; start_i = 1'b0; has_ad_i = 1'b0; has_ct_i = 1'b0;
        key_i = '0; nonce_i = '0; tag_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 128'({in_ready_o, pt_valid_o, busy_o, done_o, tag_ok_o, pt_o}), 128'(0));
        rst_n = 1'b1;

        s_empty(KAT_TAG, 1'b1, "s1");
        s_empty(KAT_TAG ^ 128'd1, 1'b0, "s2");

        // 2 AD + 3 CT, valid offered only when ready
        blk[0] = 64'h0001020304050607; blk[1] = 64'h08090a0b0c0d0e0f;
        blk[2] = 64'h1111111111111111; blk[3] = 64'hdeadbeefcafef00d;
        blk[4] = 64'h0123456789abcdef;
        model(KN, KN, 2, 3, mt);
        exp_ctag = mt;
        run_msg(KN, KN, mt, 2, 3, 1'b0, -1, -1);
        chk("s3_done_cyc", 128'(done_cyc), 128'(61));
        chk("s3_tag_ok",   128'(ok_at_done), 128'(1));
        chk("s3_nrdy",     128'(nrdy), 128'(5));
        chk("s3_hs0",      128'(hs_cyc[0]), 128'(13));
        chk("s3_npt",      128'(npt), 128'(3));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s3_pt%0d", i), 128'(got_pt[i]), 128'(exp_pt[i]));
            chk($sformatf("s3_pt%0d_cyc", i), 128'(pt_cyc[i]), 128'(hs_cyc[2+i] + 1));
        end
        chk("s3_busy", 128'(busy_bad), 128'(0));
`ifdef IMT_ASCON_DEC_TAG_OUT_EN
        chk("s3_tag_o", 128'(tag_o_bad), 128'(0));
`endif

        // CT only, valid held high, stray start mid-message, inputs scrambled after start
        blk[0] = 64'hfedcba9876543210; blk[1] = 64'h5a5a5a5aa5a5a5a5; blk[2] = 64'h0;
        model(128'h00112233445566778899aabbccddeeff, 128'hf0e0d0c0b0a090807060504030201000, 0, 3, mt);
        exp_ctag = mt;
        run_msg(128'h00112233445566778899aabbccddeeff, 128'hf0e0d0c0b0a090807060504030201000,
                mt, 0, 3, 1'b1, -1, 16);
        chk("s4_hs0",      128'(hs_cyc[0]), 128'(13));
        chk("s4_gap01",    128'(hs_cyc[1] - hs_cyc[0]), 128'(6));
        chk("s4_gap12",    128'(hs_cyc[2] - hs_cyc[1]), 128'(6));
        chk("s4_nhs",      128'(nhs), 128'(3));
        chk("s4_done_cyc", 128'(done_cyc), 128'(43));
        chk("s4_tag_ok",   128'(ok_at_done), 128'(1));
        chk("s4_npt",      128'(npt), 128'(3));
        for (int i = 0; i < 3; i++)
            chk($sformatf("s4_pt%0d", i), 128'(got_pt[i]), 128'(exp_pt[i]));

        // reset during CT_PERM of the first CT block
        blk[0] = 64'h0f1e2d3c4b5a6978; blk[1] = 64'h8877665544332211;
        run_msg(KN, KN, KAT_TAG, 0, 2, 1'b0, 15, -1);
        chk("s5_pre_npt", 128'(npt), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("s5_rst_outs", 128'({in_ready_o, pt_valid_o, busy_o, done_o, tag_ok_o, pt_o}), 128'(0));
`ifdef IMT_ASCON_DEC_TAG_OUT_EN
        chk("s5_rst_tag_o", tag_o, 128'd0);
`endif
        rst_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done_o || busy_o) rst_done = 1;
        end
        chk("s5_idle_in_rst", 128'(rst_done), 128'(0));
        rst_n = 1'b1;
        s_empty(KAT_TAG, 1'b1, "s5_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
